// File: rtl/csr_unit_if.sv
// CSR unit bus: execute-path read port, writeback commands, interrupt lines and vector outputs.
interface csr_unit_if;
  logic [11:0] read_address;
  logic [31:0] read_data;
  logic        csr_write;
  logic [11:0] csr_address;
  logic [31:0] csr_data;
  logic        traped;
  logic        mret;
  logic        retired;
  logic [31:0] ecp;
  logic [3:0]  ecause;
  logic        interupt;
  logic        external_interrupt;
  logic        timer_interrupt;
  logic        sip;
  logic        tip;
  logic        eip;
  logic [31:0] trap_vector;
  logic [31:0] mret_vector;

  modport master (
    output read_address, csr_write, csr_address, csr_data, traped, mret, retired,
           ecp, ecause, interupt, external_interrupt, timer_interrupt,
    input  read_data, sip, tip, eip, trap_vector, mret_vector
  );

  modport slave (
    input  read_address, csr_write, csr_address, csr_data, traped, mret, retired,
           ecp, ecause, interupt, external_interrupt, timer_interrupt,
    output read_data, sip, tip, eip, trap_vector, mret_vector
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: zero-latency reads, writes/trap/mret applied on the next edge.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and their aliases.
module csr_unit (
  input  logic      clk,
  input  logic      reset,
  csr_unit_if.slave bus
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        msie_q, msie_d;
  logic        mtie_q, mtie_d;
  logic        meie_q, meie_d;
  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic        meip_q, meip_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;
  logic        mcause_int_q, mcause_int_d;
  logic [3:0]  mcause_code_q, mcause_code_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`endif

  logic unused_bits;
`ifdef CSR_COUNTERS_EN
  assign unused_bits = ^bus.ecp[1:0];
`else
  assign unused_bits = ^{bus.ecp[1:0], bus.retired};
`endif

  always_comb begin
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    msie_d        = msie_q;
    mtie_d        = mtie_q;
    meie_d        = meie_q;
    msip_d        = msip_q;
    mtip_d        = bus.timer_interrupt;
    meip_d        = bus.external_interrupt;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d      = mcycle_q + 64'd1;
    minstret_d    = minstret_q + {63'd0, bus.retired};
`endif
    // Trap beats mret beats a CSR write; a losing write is dropped entirely.
    if (bus.traped) begin
      mepc_d        = bus.ecp[31:2];
      mcause_int_d  = bus.interupt;
      mcause_code_d = bus.ecause;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
    end else if (bus.mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (bus.csr_write) begin
      case (bus.csr_address)
        12'h300: begin
          mie_d  = bus.csr_data[3];
          mpie_d = bus.csr_data[7];
        end
        12'h304: begin
          msie_d = bus.csr_data[3];
          mtie_d = bus.csr_data[7];
          meie_d = bus.csr_data[11];
        end
        12'h305: mtvec_d    = bus.csr_data[31:2];
        12'h340: mscratch_d = bus.csr_data;
        12'h341: mepc_d     = bus.csr_data[31:2];
        12'h342: begin
          mcause_int_d  = bus.csr_data[31];
          mcause_code_d = bus.csr_data[3:0];
        end
        12'h344: msip_d = bus.csr_data[3];
`ifdef CSR_COUNTERS_EN
        12'hB00: mcycle_d   = {mcycle_q[63:32], bus.csr_data};
        12'hB80: mcycle_d   = {bus.csr_data, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], bus.csr_data};
        12'hB82: minstret_d = {bus.csr_data, minstret_q[31:0]};
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      msie_q        <= 1'b0;
      mtie_q        <= 1'b0;
      meie_q        <= 1'b0;
      msip_q        <= 1'b0;
      mtip_q        <= 1'b0;
      meip_q        <= 1'b0;
      mtvec_q       <= 30'd0;
      mscratch_q    <= 32'd0;
      mepc_q        <= 30'd0;
      mcause_int_q  <= 1'b0;
      mcause_code_q <= 4'd0;
`ifdef CSR_COUNTERS_EN
      mcycle_q      <= 64'd0;
      minstret_q    <= 64'd0;
`endif
    end else begin
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      msie_q        <= msie_d;
      mtie_q        <= mtie_d;
      meie_q        <= meie_d;
      msip_q        <= msip_d;
      mtip_q        <= mtip_d;
      meip_q        <= meip_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_int_q  <= mcause_int_d;
      mcause_code_q <= mcause_code_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
`endif
    end
  end

  always_comb begin
    bus.read_data = 32'd0;
    case (bus.read_address)
      12'h300: bus.read_data = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      12'h301: bus.read_data = 32'h4000_0100;
      12'h304: bus.read_data = {20'd0, meie_q, 3'd0, mtie_q, 3'd0, msie_q, 3'd0};
      12'h305: bus.read_data = {mtvec_q, 2'b00};
      12'h340: bus.read_data = mscratch_q;
      12'h341: bus.read_data = {mepc_q, 2'b00};
      12'h342: bus.read_data = {mcause_int_q, 27'd0, mcause_code_q};
      12'h344: bus.read_data = {20'd0, meip_q, 3'd0, mtip_q, 3'd0, msip_q, 3'd0};
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: bus.read_data = mcycle_q[31:0];
      12'hB80, 12'hC80: bus.read_data = mcycle_q[63:32];
      12'hB02, 12'hC02: bus.read_data = minstret_q[31:0];
      12'hB82, 12'hC82: bus.read_data = minstret_q[63:32];
`endif
      default: bus.read_data = 32'd0;
    endcase
  end

  assign bus.sip         = mie_q & msie_q & msip_q;
  assign bus.tip         = mie_q & mtie_q & mtip_q;
  assign bus.eip         = mie_q & meie_q & meip_q;
  assign bus.trap_vector = {mtvec_q, 2'b00};
  assign bus.mret_vector = {mepc_q, 2'b00};

endmodule

// File: tb/tb_csr_unit.sv
// Randomized and directed bench for csr_unit against a word-level CSR model.
module tb_csr_unit;
  logic clk = 1'b0;
  logic reset;
  csr_unit_if bus();

  csr_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_mstatus = 0, m_mie = 0, m_mtvec = 0, m_mscratch = 0, m_mepc = 0, m_mcause = 0;
  logic        m_msip = 0, m_mtip = 0, m_meip = 0;
  logic [63:0] m_cycle = 0, m_instret = 0;
  logic [31:0] pend;
  logic [11:0] pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                             12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC82, 12'h123, 12'hF14};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] m_mip();
    return (m_msip ? 32'h8 : 32'h0) | (m_mtip ? 32'h80 : 32'h0) | (m_meip ? 32'h800 : 32'h0);
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return m_mstatus | 32'h1800;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip();
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step();
    logic wr;
    if (reset) begin
      m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_msip = 0; m_mtip = 0; m_meip = 0; m_cycle = 0; m_instret = 0;
      return;
    end
    wr = bus.csr_write && !bus.traped && !bus.mret;
`ifdef CSR_COUNTERS_EN
    if (wr && bus.csr_address == 12'hB00) m_cycle[31:0] = bus.csr_data;
    else if (wr && bus.csr_address == 12'hB80) m_cycle[63:32] = bus.csr_data;
    else m_cycle = m_cycle + 1;
    if (wr && bus.csr_address == 12'hB02) m_instret[31:0] = bus.csr_data;
    else if (wr && bus.csr_address == 12'hB82) m_instret[63:32] = bus.csr_data;
    else if (bus.retired) m_instret = m_instret + 1;
`endif
    if (bus.traped) begin
      m_mepc    = bus.ecp & 32'hFFFF_FFFC;
      m_mcause  = {bus.interupt, 27'd0, bus.ecause};
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else if (bus.mret) begin
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (wr) begin
      case (bus.csr_address)
        12'h300: m_mstatus  = bus.csr_data & 32'h88;
        12'h304: m_mie      = bus.csr_data & 32'h888;
        12'h305: m_mtvec    = bus.csr_data & 32'hFFFF_FFFC;
        12'h340: m_mscratch = bus.csr_data;
        12'h341: m_mepc     = bus.csr_data & 32'hFFFF_FFFC;
        12'h342: m_mcause   = bus.csr_data & 32'h8000_000F;
        12'h344: m_msip     = bus.csr_data[3];
        default: ;
      endcase
    end
    m_mtip = bus.timer_interrupt;
    m_meip = bus.external_interrupt;
  endfunction

  // Compare current outputs with the model mid-cycle, then advance the model at the edge.
  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      chk("read_data", bus.read_data, m_read(bus.read_address));
      chk("trap_vector", bus.trap_vector, m_mtvec);
      chk("mret_vector", bus.mret_vector, m_mepc);
      pend = m_mstatus[3] ? (m_mie & m_mip()) : 32'h0;
      chk("sip_tip_eip", {29'd0, bus.sip, bus.tip, bus.eip}, {29'd0, pend[3], pend[7], pend[11]});
    end
    @(posedge clk);
    model_step();
  end

  task automatic idle();
    bus.csr_write = 1'b0;
    bus.traped    = 1'b0;
    bus.mret      = 1'b0;
    bus.retired   = 1'b0;
  endtask

  task automatic csr_wr(logic [11:0] a, logic [31:0] d);
    idle();
    bus.csr_write   = 1'b1;
    bus.csr_address = a;
    bus.csr_data    = d;
    @(negedge clk);
    idle();
  endtask

  task automatic trap(logic [31:0] pc, logic [3:0] cause, logic intr);
    idle();
    bus.traped   = 1'b1;
    bus.ecp      = pc;
    bus.ecause   = cause;
    bus.interupt = intr;
    @(negedge clk);
    idle();
  endtask

  task automatic rd_lit(string n, logic [11:0] a, logic [31:0] e);
    bus.read_address = a;
    #1;
    chk(n, bus.read_data, e);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.read_address = 0; bus.csr_address = 0; bus.csr_data = 0; bus.ecp = 0;
    bus.ecause = 0; bus.interupt = 0; bus.external_interrupt = 0; bus.timer_interrupt = 0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("irq_in_reset", {29'd0, bus.sip, bus.tip, bus.eip}, 32'h0);
    chk("tvec_in_reset", bus.trap_vector, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("irq_after_reset", {29'd0, bus.sip, bus.tip, bus.eip}, 32'h0);
    chk("mret_vec_after_reset", bus.mret_vector, 32'h0);
    rd_lit("misa", 12'h301, 32'h4000_0100);
    rd_lit("mstatus_reset", 12'h300, 32'h0000_1800);

    // MIE/MPIE round trip
    csr_wr(12'h300, 32'h8);
    rd_lit("mstatus_wr", 12'h300, 32'h0000_1808);
    trap(32'h104, 4'd3, 1'b0);
    rd_lit("mepc_trap", 12'h341, 32'h104);
    rd_lit("mcause_trap", 12'h342, 32'h3);
    rd_lit("mstatus_trap", 12'h300, 32'h0000_1880);
    bus.mret = 1'b1;
    @(negedge clk);
    idle();
    rd_lit("mstatus_mret", 12'h300, 32'h0000_1888);
    chk("mret_vector_lit", bus.mret_vector, 32'h104);

    // Timer interrupt gating
    csr_wr(12'h304, 32'h80);
    csr_wr(12'h300, 32'h8);
    bus.timer_interrupt = 1'b1;
    chk("tip_before_sample", {31'd0, bus.tip}, 32'h0);
    @(negedge clk);
    chk("tip_on", {31'd0, bus.tip}, 32'h1);
    csr_wr(12'h304, 32'h0);
    chk("tip_off", {31'd0, bus.tip}, 32'h0);
    bus.timer_interrupt = 1'b0;

    // Cause encoding and trap vector
    trap(32'h203, 4'd11, 1'b1);
    rd_lit("mcause_irq", 12'h342, 32'h8000_000B);
    chk("mret_vector_align", bus.mret_vector, 32'h200);
    csr_wr(12'h305, 32'h1003);
    rd_lit("mtvec_align", 12'h305, 32'h1000);
    chk("trap_vector_lit", bus.trap_vector, 32'h1000);

    // Simultaneous trap, mret and write
    csr_wr(12'h300, 32'h8);
    idle();
    bus.traped = 1'b1; bus.mret = 1'b1; bus.csr_write = 1'b1;
    bus.csr_address = 12'h300; bus.csr_data = 32'h88;
    bus.ecp = 32'h300; bus.ecause = 4'd2; bus.interupt = 1'b0;
    @(negedge clk);
    idle();
    rd_lit("mstatus_simul", 12'h300, 32'h0000_1880);
    rd_lit("mepc_simul", 12'h341, 32'h300);

`ifdef CSR_COUNTERS_EN
    begin
      int cnt;
      csr_wr(12'hB00, 32'hFFFF_FFFF);
      csr_wr(12'hB80, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      rd_lit("mcycleh_wrap", 12'hB80, 32'h0);
      rd_lit("mcycle_wrap", 12'hB00, 32'h2);
      csr_wr(12'hB02, 32'h0);
      csr_wr(12'hB82, 32'h0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        bus.retired = 1'($urandom_range(0, 1));
        cnt += int'(bus.retired);
        @(negedge clk);
      end
      idle();
      rd_lit("minstret_count", 12'hB02, 32'(cnt));
      rd_lit("minstret_alias", 12'hC02, 32'(cnt));
    end
`else
    rd_lit("mcycle_absent", 12'hB00, 32'h0);
    csr_wr(12'hB00, 32'h55);
    rd_lit("mcycle_wr_ignored", 12'hB00, 32'h0);
`endif

    // Reset asserted together with a trap
    csr_wr(12'h340, 32'hDEAD_BEEF);
    csr_wr(12'h304, 32'h888);
    reset = 1'b1;
    bus.traped = 1'b1; bus.ecp = 32'h444; bus.ecause = 4'd5;
    @(negedge clk);
    reset = 1'b0;
    idle();
    rd_lit("mscratch_rst", 12'h340, 32'h0);
    rd_lit("mepc_rst", 12'h341, 32'h0);
    rd_lit("mcause_rst", 12'h342, 32'h0);
    rd_lit("mie_rst", 12'h304, 32'h0);
    rd_lit("mtvec_rst", 12'h305, 32'h0);
    rd_lit("mstatus_rst", 12'h300, 32'h0000_1800);
    rd_lit("misa_rst", 12'h301, 32'h4000_0100);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 99) == 0);
      bus.csr_write   = ($urandom_range(0, 2) == 0);
      bus.csr_address = pool[$urandom_range(0, 15)];
      bus.csr_data    = $urandom;
      bus.traped      = ($urandom_range(0, 9) == 0);
      bus.mret        = ($urandom_range(0, 9) == 0);
      bus.retired     = 1'($urandom_range(0, 1));
      bus.ecp         = $urandom;
      bus.ecause      = 4'($urandom_range(0, 15));
      bus.interupt    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.timer_interrupt = ~bus.timer_interrupt;
      if ($urandom_range(0, 7) == 0) bus.external_interrupt = ~bus.external_interrupt;
      bus.read_address = pool[$urandom_range(0, 15)];
      @(negedge clk);
    end
    reset = 1'b0;
    idle();
    @(negedge clk);
    #3;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
